// File: rtl/multi_consumer_pkg.sv
// Shared types and default sizing for the multi-channel valid/ready consumer.
// The FSM state enum lives here so checkers can bind to the same encoding.
package multi_consumer_pkg;

  localparam int W_DEF      = 8;
  localparam int N_DEF      = 4;
  localparam int BUSY_W_DEF = 4;

  typedef enum logic {
    WAIT = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/multi_consumer_rr_arbiter.sv
// Round-robin one-hot grant over N requesters.
// The search begins one past the last granted channel and wraps modulo N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant
);

  int   idx;
  logic found;

  // Channels are visited in priority order; the first one requesting wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      for (int i = 0; i < N; i++) begin
        if (!found && (i == idx) && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multi_consumer.sv
// N-channel valid/ready consumer with round-robin grant and a programmable busy gap.
// Optional transfer counter is enabled by defining MULTI_CONSUMER_STATS_EN.
module multi_consumer
  import multi_consumer_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int N      = N_DEF,
  parameter int BUSY_W = BUSY_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         valid,
  input  logic [N*W-1:0]       data,
  input  logic [BUSY_W-1:0]    busy_cycles,
  output logic [N-1:0]         rdy,
  output logic [W-1:0]         data_r,
  output logic [$clog2(N)-1:0] ch_r,
  output logic                 done,
`ifdef MULTI_CONSUMER_STATS_EN
  output logic [15:0]          xfer_cnt,
`endif
  output logic                 state_dbg
);

  localparam int CW = $clog2(N);

  state_t              state;
  logic [BUSY_W-1:0]   cnt;
  logic [CW-1:0]       last_q;
  logic [N-1:0]        grant;
  logic [CW-1:0]       gidx;
  logic [W-1:0]        gdata;
  logic                xfer;

  rr_arbiter #(.N(N)) u_arb (
    .req   (valid),
    .last  (last_q),
    .grant (grant)
  );

  // Handshake: channel i transfers in a cycle where valid[i] && rdy[i]. A producer
  // may drop valid at any time; an unserved channel simply loses its turn.
  assign rdy       = (!rst && state == WAIT) ? grant : '0;
  assign xfer      = |rdy;
  assign state_dbg = (state == BUSY);

  always_comb begin
    gidx  = '0;
    gdata = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        gidx  = CW'(i);
        gdata = data[i*W +: W];
      end
    end
  end

  // busy_cycles is captured only at the transfer, so later changes cannot stretch a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= WAIT;
      cnt    <= '0;
      data_r <= '0;
      ch_r   <= '0;
      done   <= 1'b0;
      last_q <= CW'(N - 1);
    end else begin
      done <= xfer;
      if (xfer) begin
        data_r <= gdata;
        ch_r   <= gidx;
        last_q <= gidx;
      end
      case (state)
        WAIT: begin
          if (xfer && busy_cycles != '0) begin
            state <= BUSY;
            cnt   <= busy_cycles;
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == BUSY_W'(1)) state <= WAIT;
        end
      endcase
    end
  end

`ifdef MULTI_CONSUMER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) xfer_cnt <= '0;
    else if (xfer) xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule
